// File: rtl/vedic_pkg.sv
// Shared definitions for the sequenced 16x16 Vedic multiplier controller:
// FSM state encoding, datapath widths, partial-product shift amounts and
// the magnitude helper used by the optional signed build.
package vedic_pkg;

    localparam int VMUL_HALF_W = 8;
    localparam int VMUL_FULL_W = 16;
    localparam int VMUL_PROD_W = 32;

    // Left shift applied to each 8x8 partial product before accumulation
    localparam int VMUL_SH_PP0  = 0;
    localparam int VMUL_SH_PP12 = 8;
    localparam int VMUL_SH_PP3  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_DONE = 3'd5
    } vmul_state_t;

    // Unsigned magnitude of a 16-bit two's-complement value; -32768 maps to 0x8000
    function automatic logic [VMUL_FULL_W-1:0] vmul_mag16(input logic [VMUL_FULL_W-1:0] v);
        logic [VMUL_FULL_W-1:0] m;
        if (v[VMUL_FULL_W-1]) begin
            m = ~v + 16'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/vedic_8X8.sv
// Combinational 8x8 unsigned Vedic multiplier core. The operands are split
// into nibbles; the four nibble products (vertical and crosswise terms) are
// aligned and summed into the 16-bit product.
module vedic_8X8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] c
);

    logic [7:0] pp_ll_s;
    logic [7:0] pp_hl_s;
    logic [7:0] pp_lh_s;
    logic [7:0] pp_hh_s;

    assign pp_ll_s = {4'd0, a[3:0]} * {4'd0, b[3:0]};
    assign pp_hl_s = {4'd0, a[7:4]} * {4'd0, b[3:0]};
    assign pp_lh_s = {4'd0, a[3:0]} * {4'd0, b[7:4]};
    assign pp_hh_s = {4'd0, a[7:4]} * {4'd0, b[7:4]};

    // Vertical terms at weight 1 and 256, crosswise terms at weight 16
    assign c = {8'd0, pp_ll_s}
             + {4'd0, pp_hl_s, 4'd0}
             + {4'd0, pp_lh_s, 4'd0}
             + {pp_hh_s, 8'd0};

endmodule

// File: rtl/vedic_seq16_ctrl.sv
// 16x16 multiplier built by time-multiplexing one vedic_8X8 core over four
// partial-product cycles, with valid/ready handshakes on both sides.
// Optional build macro: VMUL_SIGNED_EN (two's-complement operands via
// sign/magnitude; when undefined the operands are unsigned and no sign
// logic exists).
module vedic_seq16_ctrl
    import vedic_pkg::*;
#(
    parameter int W_HALF = VMUL_HALF_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);

    vmul_state_t              state_r;
    vmul_state_t              state_nxt_s;
    logic [VMUL_FULL_W-1:0]   ra_r;
    logic [VMUL_FULL_W-1:0]   rb_r;
    logic [VMUL_PROD_W-1:0]   acc_r;
    logic [VMUL_PROD_W-1:0]   out_p_r;
    logic                     out_valid_r;
`ifdef VMUL_SIGNED_EN
    logic                     neg_r;
`endif

    logic [W_HALF-1:0]        core_a_s;
    logic [W_HALF-1:0]        core_b_s;
    logic [2*W_HALF-1:0]      core_c_s;
    logic [VMUL_PROD_W-1:0]   pp_term_s;
    logic [VMUL_PROD_W-1:0]   acc_sum_s;
    logic [VMUL_PROD_W-1:0]   final_s;
    logic [VMUL_FULL_W-1:0]   in_a_lat_s;
    logic [VMUL_FULL_W-1:0]   in_b_lat_s;

    vedic_8X8 u_core (
        .a (core_a_s),
        .b (core_b_s),
        .c (core_c_s)
    );

    // Operand values captured at acceptance: raw in the unsigned build, magnitudes otherwise
`ifdef VMUL_SIGNED_EN
    assign in_a_lat_s = vmul_mag16(in_a);
    assign in_b_lat_s = vmul_mag16(in_b);
`else
    assign in_a_lat_s = in_a;
    assign in_b_lat_s = in_b;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-state core operand selection (idle operands are zero)
    always_comb begin
        state_nxt_s = state_r;
        core_a_s    = {W_HALF{1'b0}};
        core_b_s    = {W_HALF{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_PP0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PP0: begin
                core_a_s    = ra_r[W_HALF-1:0];
                core_b_s    = rb_r[W_HALF-1:0];
                state_nxt_s = ST_PP1;
            end
            ST_PP1: begin
                core_a_s    = ra_r[2*W_HALF-1:W_HALF];
                core_b_s    = rb_r[W_HALF-1:0];
                state_nxt_s = ST_PP2;
            end
            ST_PP2: begin
                core_a_s    = ra_r[W_HALF-1:0];
                core_b_s    = rb_r[2*W_HALF-1:W_HALF];
                state_nxt_s = ST_PP3;
            end
            ST_PP3: begin
                core_a_s    = ra_r[2*W_HALF-1:W_HALF];
                core_b_s    = rb_r[2*W_HALF-1:W_HALF];
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Align the current core product and add it into the running sum
    always_comb begin
        pp_term_s = {VMUL_PROD_W{1'b0}};
        acc_sum_s = acc_r;
        case (state_r)
            ST_PP0: begin
                pp_term_s = {16'd0, core_c_s} << VMUL_SH_PP0;
                acc_sum_s = pp_term_s;
            end
            ST_PP1, ST_PP2: begin
                pp_term_s = {16'd0, core_c_s} << VMUL_SH_PP12;
                acc_sum_s = acc_r + pp_term_s;
            end
            ST_PP3: begin
                pp_term_s = {16'd0, core_c_s} << VMUL_SH_PP3;
                acc_sum_s = acc_r + pp_term_s;
            end
            default: begin
                pp_term_s = {VMUL_PROD_W{1'b0}};
                acc_sum_s = acc_r;
            end
        endcase
    end

    // Final product: negated when exactly one operand was negative
    always_comb begin
        final_s = acc_sum_s;
`ifdef VMUL_SIGNED_EN
        if (neg_r) begin
            final_s = ~acc_sum_s + 32'd1;
        end else begin
            final_s = acc_sum_s;
        end
`endif
    end

    // Operand capture, accumulation and registered result handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_r        <= 16'd0;
            rb_r        <= 16'd0;
            acc_r       <= 32'd0;
            out_p_r     <= 32'd0;
            out_valid_r <= 1'b0;
`ifdef VMUL_SIGNED_EN
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        ra_r  <= in_a_lat_s;
                        rb_r  <= in_b_lat_s;
                        acc_r <= 32'd0;
`ifdef VMUL_SIGNED_EN
                        neg_r <= in_a[15] ^ in_b[15];
`endif
                    end
                end
                ST_PP0, ST_PP1, ST_PP2: begin
                    acc_r <= acc_sum_s;
                end
                ST_PP3: begin
                    acc_r       <= final_s;
                    out_p_r     <= final_s;
                    out_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_p     = out_p_r;

endmodule

// File: doc/vedic_seq16_ctrl.md
# vedic_seq16_ctrl

Sequencing controller that computes a 16x16 product by time-multiplexing a single `vedic_8X8` core over four partial-product cycles. It sits between a valid/ready requester and a valid/ready consumer, trading throughput for area (one 8x8 core instead of four). It owns the core's `a`/`b` operand inputs, reads its `c` output, and accumulates the shifted partial products into a 32-bit result.

## Interface
- `W_HALF`, default 8, operand half-width. Must match the `vedic_8X8` core; fixed at 8.
- `clk`  in  1  sole clock; all flops rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  controller can accept; high only in IDLE.
- `in_a`  in  16  multiplicand.
- `in_b`  in  16  multiplier.
- `out_valid`  out  1  `out_p` holds a completed product.
- `out_ready`  in  1  consumer accepts `out_p`.
- `out_p`  out  32  product.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, PP0, PP1, PP2, PP3, DONE.
- IDLE, `in_valid && in_ready`:
  - latch `in_a`/`in_b` into operand registers `ra`/`rb`;
  - clear `acc`;
  - go to PP0.
- Core operands and accumulation per state:
  - PP0: `ra[7:0]`, `rb[7:0]`; `acc <= c`.
  - PP1: `ra[15:8]`, `rb[7:0]`; `acc <= acc + (c << 8)`.
  - PP2: `ra[7:0]`, `rb[15:8]`; `acc <= acc + (c << 8)`.
  - PP3: `ra[15:8]`, `rb[15:8]`; `acc <= acc + (c << 16)`; go to DONE.
- Operands are driven combinationally from `ra`/`rb` by state. The core output is sampled in the same cycle.
- `acc` is 32 bits. No intermediate or final overflow is possible: the maximum is 0xFFFE0001.
- In DONE: `out_valid=1` and `out_p=acc`. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is low in DONE, so there is no overlap between operations.
- `out_p` and `out_valid` hold stable while `out_ready` is low.
- `in_a`/`in_b` are ignored outside the accepting edge.
- Idle core operands are driven to 0.

## Timing
- Reset values:
  - state IDLE;
  - `ra`, `rb`, `acc`, `out_p` = 0;
  - `out_valid` = 0;
  - `busy` = 0;
  - `in_ready` = 1 (decoded from IDLE).
- Latency: acceptance at edge T, then `out_valid` is high after edge T+4. The fastest result handoff is at edge T+5 with `out_ready` tied high.
- Throughput: one result every 6 cycles with no backpressure. `in_ready` returns high the cycle after the output handshake.
- Reset asserted mid-operation (any of PP0–DONE): all state clears immediately. No `out_valid` pulse occurs for the aborted operation.
- `in_valid` held high in DONE: not accepted until the controller returns to IDLE.

## Configuration
- `VMUL_SIGNED_EN` defined:
  - `in_a`/`in_b` are two's complement.
  - At acceptance, latch their magnitudes (16-bit unsigned; |−32768| = 0x8000) and a sign flag `sa^sb`.
  - On the PP3 → DONE transition, load `-acc_final` if the sign flag is set.
  - −32768 × −32768 = 0x40000000 fits.
- Not defined:
  - operands are unsigned;
  - no sign or magnitude logic is synthesized.

## Structure
- Shared package `vedic_pkg`:
  - FSM state enum `vmul_state_t`;
  - `VMUL_HALF_W=8`;
  - `VMUL_FULL_W=16`;
  - `VMUL_PROD_W=32`;
  - partial-product shift constants 0/8/16.
- One sub-module: the existing `vedic_8X8`, instantiated once. Ports are `a[7:0]`, `b[7:0]`, `c[15:0]`.
- The controller itself is a single module, roughly 150–250 lines.

## Test plan
- Reset:
  - hold `rst_n` low, release;
  - expect `in_ready=1`, `out_valid=0`, `out_p=0`, `busy=0`.
- Basic, `out_ready=1`:
  - 5 × 3 → `out_p=0x0000000F`;
  - `out_valid` asserts exactly 4 cycles after acceptance and lasts 1 cycle.
- Max unsigned: 0xFFFF × 0xFFFF → `out_p=0xFFFE0001`.
- Backpressure:
  - 0x1234 × 0x00FF with `out_ready` low for 3 cycles → `out_p=0x001221CC`, held stable;
  - `in_ready=0` throughout, and a pending `in_valid` is not accepted until after the handshake.
- Reset mid-op:
  - start 0xFFFF × 0x0002, pull `rst_n` low during PP2 → no `out_valid`;
  - a following 2 × 2 yields 0x00000004.
- Signed:
  - with `VMUL_SIGNED_EN`: 0xFFFD × 0x0005 → 0xFFFFFFF1, and 0x8000 × 0x8000 → 0x40000000;
  - without it: 0xFFFD × 0x0005 → 0x0004FFF1.
